// File: rtl/led_pattern_monitor.sv
// Watches a 4-bit LED bus for the S1->S2->S3 warning sequence; flags illegal patterns, illegal steps and stuck patterns.
// Outputs lag led by 1 clk (errors by 2); macro LED_MON_CYCLE_COUNT_EN builds the S3->S1 wrap counter.
module led_pattern_monitor #(
  parameter int unsigned MAX_TICKS = 4,
  parameter logic [3:0]  P_S1      = 4'b0000,
  parameter logic [3:0]  P_S2      = 4'b1100,
  parameter logic [3:0]  P_S3      = 4'b0011
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       tick,
  input  logic       clear,
  input  logic [3:0] led,
  output logic [1:0] phase,
  output logic       phase_valid,
  output logic       seq_err,
  output logic       stuck_err,
  output logic [7:0] cycle_count
);

  localparam logic [7:0] LP_MAX_TICKS = MAX_TICKS[7:0];

  logic [3:0] r_led_q;
  logic [3:0] r_led_p;
  logic [7:0] r_dwell;
  logic       r_seq_err;
  logic       r_stuck_err;

  logic       w_chg;
  logic       w_legal_step;
  logic       w_seq_bad;
  logic       w_stuck_bad;

  always_comb begin
    phase       = 2'd3;
    phase_valid = 1'b0;
    if (r_led_q == P_S1) begin
      phase       = 2'd0;
      phase_valid = 1'b1;
    end else if (r_led_q == P_S2) begin
      phase       = 2'd1;
      phase_valid = 1'b1;
    end else if (r_led_q == P_S3) begin
      phase       = 2'd2;
      phase_valid = 1'b1;
    end
  end

  // Any move into S1 is legal: it is the sequencer's recovery path.
  assign w_chg        = (r_led_q != r_led_p);
  assign w_legal_step = (r_led_q == P_S1) ||
                        ((r_led_p == P_S1) && (r_led_q == P_S2)) ||
                        ((r_led_p == P_S2) && (r_led_q == P_S3));
  assign w_seq_bad    = !phase_valid || (w_chg && !w_legal_step);
  assign w_stuck_bad  = enable && (r_dwell > LP_MAX_TICKS);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_led_q     <= P_S1;
      r_led_p     <= P_S1;
      r_dwell     <= 8'd0;
      r_seq_err   <= 1'b0;
      r_stuck_err <= 1'b0;
    end else begin
      r_led_q <= led;
      r_led_p <= r_led_q;
      if (w_chg) begin
        r_dwell <= 8'd0;
      end else if (enable && tick && (r_dwell != 8'hFF)) begin
        r_dwell <= r_dwell + 8'd1;
      end
      // A new error in the same clk as clear keeps the flag set.
      r_seq_err   <= (r_seq_err && !clear) || w_seq_bad;
      r_stuck_err <= (r_stuck_err && !clear) || w_stuck_bad;
    end
  end

  assign seq_err   = r_seq_err;
  assign stuck_err = r_stuck_err;

`ifdef LED_MON_CYCLE_COUNT_EN
  logic [7:0] r_cycle_count;
  logic       w_wrap;

  assign w_wrap = w_chg && (r_led_p == P_S3) && (r_led_q == P_S1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cycle_count <= 8'd0;
    end else if (w_wrap && (r_cycle_count != 8'hFF)) begin
      r_cycle_count <= r_cycle_count + 8'd1;
    end
  end

  assign cycle_count = r_cycle_count;
`else
  assign cycle_count = 8'd0;
`endif

endmodule

// File: tb/tb_led_pattern_monitor.sv
// Directed bench for led_pattern_monitor: linear steps with hand-computed expectations.
module tb_led_pattern_monitor;

  localparam logic [3:0] S1 = 4'b0000;
  localparam logic [3:0] S2 = 4'b1100;
  localparam logic [3:0] S3 = 4'b0011;

`ifdef LED_MON_CYCLE_COUNT_EN
  localparam int CC_AFTER_3   = 3;
  localparam int CC_SATURATED = 255;
`else
  localparam int CC_AFTER_3   = 0;
  localparam int CC_SATURATED = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       tick;
  logic       clear;
  logic [3:0] led;
  logic [1:0] phase;
  logic       phase_valid;
  logic       seq_err;
  logic       stuck_err;
  logic [7:0] cycle_count;

  int n_checks = 0;
  int n_errors = 0;

  led_pattern_monitor #(
    .MAX_TICKS (4),
    .P_S1      (S1),
    .P_S2      (S2),
    .P_S3      (S3)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .tick        (tick),
    .clear       (clear),
    .led         (led),
    .phase       (phase),
    .phase_valid (phase_valid),
    .seq_err     (seq_err),
    .stuck_err   (stuck_err),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_phase"}, 32'(phase), 32'd0);
    chk({tag, "_phase_valid"}, 32'(phase_valid), 32'd1);
    chk({tag, "_seq_err"}, 32'(seq_err), 32'd0);
    chk({tag, "_stuck_err"}, 32'(stuck_err), 32'd0);
    chk({tag, "_cycle_count"}, 32'(cycle_count), 32'd0);
  endtask

  initial begin
    logic [3:0] pats [3];
    logic [1:0] phs  [3];
    pats[0] = S2; pats[1] = S3; pats[2] = S1;
    phs[0]  = 2'd1; phs[1] = 2'd2; phs[2] = 2'd0;

    // Reset state
    reset_n = 1'b0; enable = 1'b0; tick = 1'b0; clear = 1'b0; led = S1;
    step(2);
    chk_reset_vals("reset");
    reset_n = 1'b1;
    step(1);

    // Legal sequence: 3 full cycles, tick every 4 clk
    enable = 1'b1;
    for (int c = 0; c < 3; c++) begin
      for (int s = 0; s < 3; s++) begin
        led  = pats[s];
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        chk($sformatf("legal_phase_c%0d_s%0d", c, s), 32'(phase), 32'(phs[s]));
        step(3);
      end
    end
    chk("legal_seq_err", 32'(seq_err), 32'd0);
    chk("legal_stuck_err", 32'(stuck_err), 32'd0);
    chk("legal_cycle_count", 32'(cycle_count), 32'(CC_AFTER_3));

    // Illegal transition S1 -> S3, then clear
    led = S3;
    step(1);
    chk("illegal_phase", 32'(phase), 32'd2);
    step(1);
    chk("illegal_seq_err", 32'(seq_err), 32'd1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("illegal_cleared", 32'(seq_err), 32'd0);
    led = S1;
    step(3);
    chk("recover_no_err", 32'(seq_err), 32'd0);

    // Unknown pattern, then back to S1
    led = 4'b1010;
    step(1);
    chk("unknown_phase", 32'(phase), 32'd3);
    chk("unknown_phase_valid", 32'(phase_valid), 32'd0);
    step(1);
    chk("unknown_seq_err", 32'(seq_err), 32'd1);
    led = S1;
    step(1);
    chk("unknown_back_phase", 32'(phase), 32'd0);
    chk("unknown_back_valid", 32'(phase_valid), 32'd1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    step(1);
    chk("unknown_back_no_err", 32'(seq_err), 32'd0);

    // Stuck pattern with enable=1: set only after the 5th tick
    led = S2;
    step(2);
    for (int i = 0; i < 4; i++) begin
      tick = 1'b1; step(1); tick = 1'b0; step(1);
    end
    chk("stuck_after_4_ticks", 32'(stuck_err), 32'd0);
    tick = 1'b1; step(1); tick = 1'b0; step(1);
    chk("stuck_after_5_ticks", 32'(stuck_err), 32'd1);
    enable = 1'b0;
    clear  = 1'b1;
    step(1);
    clear = 1'b0;
    chk("stuck_cleared", 32'(stuck_err), 32'd0);

    // Same hold with enable=0: never stuck
    led = S3;
    step(2);
    for (int i = 0; i < 6; i++) begin
      tick = 1'b1; step(1); tick = 1'b0; step(1);
    end
    chk("stuck_disabled", 32'(stuck_err), 32'd0);
    chk("stuck_disabled_seq", 32'(seq_err), 32'd0);
    enable = 1'b1;

    // Clear colliding with an illegal S1 -> S3 step
    led = S1; step(2);
    led = S2; step(2);
    led = S1; step(2);
    led = S3; step(1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("collision_err_wins", 32'(seq_err), 32'd1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("collision_cleared", 32'(seq_err), 32'd0);

    // Saturation: 260+ legal cycles, one step per clk
    led = S1; step(1);
    for (int c = 0; c < 260; c++) begin
      led = S2; step(1);
      led = S3; step(1);
      led = S1; step(1);
    end
    step(2);
    chk("sat_cycle_count", 32'(cycle_count), 32'(CC_SATURATED));
    chk("sat_seq_err", 32'(seq_err), 32'd0);

    // Reset mid-sequence with an error pending
    led = 4'b1010; step(2);
    chk("pre_reset_seq_err", 32'(seq_err), 32'd1);
    led = S2; step(1);
    reset_n = 1'b0;
    step(1);
    chk_reset_vals("midreset");
    reset_n = 1'b1;
    step(1);
    chk("post_reset_phase", 32'(phase), 32'd1);
    step(1);
    chk("post_reset_seq_err", 32'(seq_err), 32'd0);
    chk("post_reset_cycle_count", 32'(cycle_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
